stream_mem_responder: RTL and testbench
=======================================

# stream_mem_responder

Memory-side endpoint of the processor's 128-bit request/response AXI-stream link. It consumes request streams: one `tuser` header beat, followed by write data beats when the request is a write. It performs the word accesses on a fixed-latency 128-bit memory port and returns read data as a response stream. It sits opposite the processor bridge, either as a BRAM-backed main-memory stand-in or as the front end of a DRAM controller.

## Interface
- `ADDR_WIDTH`, default 27: header address and stream-length width, in 128-bit word units.
- `READ_LATENCY`, default 2: cycles from a read issue (`mem_en && !mem_wen`) to valid `mem_rdata`. Must be ≥1.
- `RESP_DEPTH`, default 4: response FIFO entries. Must be ≥ `READ_LATENCY`+1 and a power of 2.

Ports:
- `clk_in`  in  1  single clock; all logic is on its rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `req_axis_data`  in  128  header or write data.
- `req_axis_tuser`  in  1  1 marks a header beat.
- `req_axis_valid`  in  1  request beat valid.
- `req_axis_ready`  out  1  request beat accepted when high with valid.
- `resp_axis_data`  out  128  read data beat.
- `resp_axis_tuser`  out  1  tied 0.
- `resp_axis_valid`  out  1  response beat valid.
- `resp_axis_ready`  in  1  downstream accepts a response beat.
- `mem_en`  out  1  memory access strobe.
- `mem_wen`  out  1  write when 1, read when 0; qualified by `mem_en`.
- `mem_addr`  out  ADDR_WIDTH  word address.
- `mem_wdata`  out  128  write data.
- `mem_rdata`  in  128  read data, valid `READ_LATENCY` cycles after a read issue; no backpressure.
- `protocol_err`  out  1  one-cycle pulse on a malformed stream.

## Operation
- Header layout in `req_axis_data[54:0]`:
  - `[54:28]` addr
  - `[27:1]` stream_length (number of words)
  - `[0]` wen
  - `[127:55]` ignored.
- Internal state: base address, remaining count, word offset.
- **IDLE**: `req_axis_ready`=1.
  - Header accepted with length 0: stay in IDLE, no memory activity.
  - Header accepted with wen=1: go to WRITE.
  - Header accepted with wen=0: go to READ.
  - Non-header beat accepted: discarded, `protocol_err` pulses.
- **WRITE**: `req_axis_ready`=1.
  - Each data beat accepted at offset i produces one registered write to `addr+i`.
  - After the last beat, return to IDLE.
  - A header beat arriving in WRITE aborts the write (remaining words are not written), pulses `protocol_err`, and is processed as a new header that same cycle.
- **READ**: `req_axis_ready`=0.
  - Issue one read per cycle to `addr+i` while `credits < RESP_DEPTH`.
  - `credits` = reads in flight + FIFO occupancy.
  - After the last issue, return to IDLE. Remaining in-flight data still drains in order.
  - The next header may be accepted while that data drains. Order is preserved because memory accesses are issued in order.
- Address arithmetic is modulo 2^ADDR_WIDTH: `addr+i` wraps to 0.
- Read return path: a shift register of valid bits, `READ_LATENCY` deep, marks `mem_rdata` capture. The FIFO writes on capture and pops on `resp_axis_valid && resp_axis_ready`. Pop and push may occur in the same cycle.
- The credit check guarantees the FIFO never overflows. An overflow condition is a design error; assert it in simulation.

## Timing
- Reset: all outputs are 0 during reset and on the first cycle after it, except `req_axis_ready`, which rises the first cycle after reset. State is IDLE, FIFO empty, in-flight bits cleared.
- Reset mid-operation aborts the transfer. Returning read data is dropped and no partial response is emitted.
- Write: beat accepted in cycle k → `mem_en`=1, `mem_wen`=1, with addr and data, in cycle k+1. The header costs 1 cycle, so 4 words take 5 accept cycles back-to-back.
- Read: header accepted in cycle 0 → first read issued in cycle 1 → captured at 1+L → `resp_axis_valid` at 2+L (4 for L=2). With `resp_axis_ready` held at 1, there is one beat per cycle thereafter.
- `resp_axis_data`/`resp_axis_valid` are stable while valid=1 and ready=0.
- `mem_en`=0 in any cycle without an issued access. `mem_wdata` is don't-care on reads.
- `protocol_err` is asserted the cycle after the offending beat is accepted.

## Test plan
- Write header (addr 0x40, len 4, wen 1), then beats D0..D3 → writes to 0x40..0x43 in order on cycles 2..5. A subsequent read header (0x40, len 4) returns D0..D3, with the first `resp_axis_valid` 4 cycles after header accept.
- Read len 8 with `resp_axis_ready`=0 → exactly `RESP_DEPTH`=4 reads issued, then `mem_en` stays low. Releasing ready → all 8 words are delivered in address order with no loss or duplication.
- Header with len 0 (wen 0 and wen 1) → no `mem_en`, no response, `req_axis_ready` stays 1, no error.
- Write len 4 interrupted after 2 beats by a read header (0x10, len 1) → only 2 words written, `protocol_err` pulses once, one response beat from 0x10.
- Read header (0x7FFFFFF, len 2) → reads to 0x7FFFFFF then 0x0000000.
- Randomized `resp_axis_ready` over back-to-back read headers (len 4 ×3), and reset asserted mid-stream → responses match the scoreboard. After reset: no valid, empty FIFO, and the next transaction is correct.

Source files
------------

// File: rtl/stream_mem_responder.sv
// stream_mem_responder: 128-bit request/response AXI-stream endpoint
// driving a fixed-latency memory port.
module stream_mem_responder #(
    parameter int ADDR_WIDTH   = 27,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [127:0]          req_axis_data,
    input  logic                  req_axis_tuser,
    input  logic                  req_axis_valid,
    output logic                  req_axis_ready,
    output logic [127:0]          resp_axis_data,
    output logic                  resp_axis_tuser,
    output logic                  resp_axis_valid,
    input  logic                  resp_axis_ready,
    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [127:0]          mem_wdata,
    input  logic [127:0]          mem_rdata,
    output logic                  protocol_err
);

    localparam int AW = ADDR_WIDTH;
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t                  state, state_n;
    logic                    rdy_q;
    logic [AW-1:0]           cur_addr, cur_addr_n;
    logic [AW-1:0]           left, left_n;
    logic                    iss_en, iss_wen, err_c;
    logic [AW-1:0]           iss_addr;
    logic [CW-1:0]           credits, fifo_cnt;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [127:0]            fifo [RESP_DEPTH];
    logic [READ_LATENCY-1:0] vld;
    logic                    accept, hdr, beat;
    logic                    push, pop, can_issue;
    logic [AW-1:0]           h_addr, h_len;
    logic                    h_wen;

    assign req_axis_ready  = rdy_q & ~rst_in;
    assign accept          = req_axis_valid & req_axis_ready;
    assign hdr             = accept & req_axis_tuser;
    assign beat            = accept & ~req_axis_tuser;
    assign h_addr          = AW'(req_axis_data[54:28]);
    assign h_len           = AW'(req_axis_data[27:1]);
    assign h_wen           = req_axis_data[0];

    assign resp_axis_valid = fifo_cnt != '0;
    assign resp_axis_data  = resp_axis_valid ? fifo[rd_ptr] : '0;
    assign resp_axis_tuser = 1'b0;
    assign push            = vld[READ_LATENCY-1];
    assign pop             = resp_axis_valid & resp_axis_ready;
    // A same-cycle pop frees its slot, keeping one read per cycle.
    assign can_issue       = (credits - CW'(pop)) < CW'(RESP_DEPTH);

    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        left_n     = left;
        iss_en     = 1'b0;
        iss_wen    = 1'b0;
        iss_addr   = cur_addr;
        err_c      = 1'b0;
        if (hdr) begin
            err_c      = state == S_WRITE;
            state_n    = S_IDLE;
            cur_addr_n = h_addr;
            left_n     = h_len;
            if (h_len != '0) begin
                if (h_wen) begin
                    state_n = S_WRITE;
                end else if (can_issue) begin
                    iss_en     = 1'b1;
                    iss_addr   = h_addr;
                    cur_addr_n = h_addr + AW'(1);
                    left_n     = h_len - AW'(1);
                    state_n    = (h_len == AW'(1)) ? S_IDLE : S_READ;
                end else begin
                    state_n = S_READ;
                end
            end
        end else begin
            case (state)
                S_IDLE: err_c = beat;
                S_WRITE: begin
                    if (beat) begin
                        iss_en     = 1'b1;
                        iss_wen    = 1'b1;
                        cur_addr_n = cur_addr + AW'(1);
                        left_n     = left - AW'(1);
                        if (left == AW'(1)) state_n = S_IDLE;
                    end
                end
                S_READ: begin
                    if (can_issue) begin
                        iss_en     = 1'b1;
                        cur_addr_n = cur_addr + AW'(1);
                        left_n     = left - AW'(1);
                        if (left == AW'(1)) state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            rdy_q        <= 1'b1;
            cur_addr     <= '0;
            left         <= '0;
            mem_en       <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            protocol_err <= 1'b0;
            credits      <= '0;
            vld          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
        end else begin
            state        <= state_n;
            rdy_q        <= state_n != S_READ;
            cur_addr     <= cur_addr_n;
            left         <= left_n;
            mem_en       <= iss_en;
            mem_wen      <= iss_wen;
            protocol_err <= err_c;
            if (iss_en) mem_addr <= iss_addr;
            if (iss_wen) mem_wdata <= req_axis_data;
            credits  <= credits + CW'(iss_en & ~iss_wen) - CW'(pop);
            vld      <= (vld << 1) | READ_LATENCY'(mem_en & ~mem_wen);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo[wr_ptr] <= mem_rdata;
        if (!rst_in) begin
            assert (!(push && !pop && fifo_cnt == CW'(RESP_DEPTH)));
        end
    end

endmodule

// File: tb/tb_stream_mem_responder.sv
// Directed bench for stream_mem_responder with a 2-cycle memory model.
module tb_stream_mem_responder;

    logic         clk_in, rst_in;
    logic [127:0] req_axis_data;
    logic         req_axis_tuser, req_axis_valid, req_axis_ready;
    logic [127:0] resp_axis_data;
    logic         resp_axis_tuser, resp_axis_valid, resp_axis_ready;
    logic         mem_en, mem_wen;
    logic [26:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         protocol_err;

    stream_mem_responder #(
        .ADDR_WIDTH(27), .READ_LATENCY(2), .RESP_DEPTH(4)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_axis_data(req_axis_data), .req_axis_tuser(req_axis_tuser),
        .req_axis_valid(req_axis_valid), .req_axis_ready(req_axis_ready),
        .resp_axis_data(resp_axis_data), .resp_axis_tuser(resp_axis_tuser),
        .resp_axis_valid(resp_axis_valid), .resp_axis_ready(resp_axis_ready),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .protocol_err(protocol_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    bit rr_rand = 0;

    localparam logic [127:0] D0 = 128'h0123456789ABCDEF_0011223344556677;
    localparam logic [127:0] D1 = 128'hFEDCBA9876543210_8899AABBCCDDEEFF;
    localparam logic [127:0] D2 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] D3 = 128'h13579BDF_2468ACE0_DEADBEEF_CAFEF00D;

    function automatic logic [127:0] pat(input logic [26:0] a);
        return {5'h1A, a, 5'h05, ~a, 5'h00, a, 32'h5A5A_5A5A};
    endfunction

    function automatic logic [127:0] h(input logic [26:0] a,
                                       input logic [26:0] l,
                                       input logic w);
        return {73'd0, a, l, w};
    endfunction

    // memory model: fixed 2-cycle read latency
    logic [127:0] mem [logic [26:0]];
    logic [127:0] rq0, rq1;
    assign mem_rdata = rq1;
    always @(posedge clk_in)
        if (mem_en && mem_wen) mem[mem_addr] = mem_wdata;
    always @(posedge clk_in) begin
        rq1 <= rq0;
        rq0 <= mem.exists(mem_addr) ? mem[mem_addr] : pat(mem_addr);
    end

    logic [26:0]  w_addrs[$];
    logic [26:0]  r_addrs[$];
    logic [127:0] got[$];
    int           err_cnt;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (mem_en && mem_wen) w_addrs.push_back(mem_addr);
            if (mem_en && !mem_wen) r_addrs.push_back(mem_addr);
            if (protocol_err) err_cnt++;
            if (resp_axis_valid && resp_axis_ready)
                got.push_back(resp_axis_data);
        end
    end

    task automatic clr();
        w_addrs.delete();
        r_addrs.delete();
        got.delete();
        err_cnt = 0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] gq(input int i);
        return (i < got.size()) ? got[i] : '1;
    endfunction
    function automatic logic [26:0] rq(input int i);
        return (i < r_addrs.size()) ? r_addrs[i] : '1;
    endfunction
    function automatic logic [26:0] wq(input int i);
        return (i < w_addrs.size()) ? w_addrs[i] : '1;
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
        if (rr_rand) resp_axis_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic t, input logic [127:0] d);
        int k = 0;
        bit ok = 0;
        req_axis_valid = 1'b1;
        req_axis_tuser = t;
        req_axis_data  = d;
        while (!ok && k < 100) begin
            @(negedge clk_in);
            if (req_axis_ready) ok = 1;
            else begin
                cyc();
                k++;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: ready low %0d cycles", k);
        end
        cyc();
        req_axis_valid = 1'b0;
        req_axis_tuser = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, input string nm);
        int k = 0;
        while (got.size() < n && k < budget) begin
            cyc();
            k++;
        end
        if (got.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d beats expected %0d",
                     nm, got.size(), n);
        end
    endtask

    typedef struct {
        logic         v, t;
        logic [127:0] d;
        logic         rr;
        logic         e_rdy, e_en, e_wen;
        logic [26:0]  e_addr;
        logic [127:0] e_wd;
        logic         e_rv;
        logic [127:0] e_rd;
        logic         e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic v, t, input logic [127:0] d, input logic rr,
        input logic rdy, en, wen, input logic [26:0] a,
        input logic [127:0] wd, input logic rv, input logic [127:0] rd,
        input logic err);
        vec_t r;
        r.v = v; r.t = t; r.d = d; r.rr = rr;
        r.e_rdy = rdy; r.e_en = en; r.e_wen = wen; r.e_addr = a;
        r.e_wd = wd; r.e_rv = rv; r.e_rd = rd; r.e_err = err;
        return r;
    endfunction

    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        rst_in = 1'b1;
        req_axis_valid = 1'b0;
        req_axis_tuser = 1'b0;
        req_axis_data = '0;
        resp_axis_ready = 1'b1;
        clr();

        // write 0x40..0x43, read back, zero-length headers, stray beat
        tbl[0]  = mk(1, 1, h(27'h40, 4, 1), 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, D0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, D1, 1, 1, 1, 1, 27'h40, D0, 0, 0, 0);
        tbl[3]  = mk(1, 0, D2, 1, 1, 1, 1, 27'h41, D1, 0, 0, 0);
        tbl[4]  = mk(1, 0, D3, 1, 1, 1, 1, 27'h42, D2, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 1, 1, 1, 27'h43, D3, 0, 0, 0);
        tbl[6]  = mk(1, 1, h(27'h40, 4, 0), 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0, 1, 0, 27'h40, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 1, 0, 27'h41, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 1, 0, 27'h42, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 1, 0, 27'h43, 0, 1, D0, 0);
        tbl[11] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, D1, 0);
        tbl[12] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, D2, 0);
        tbl[13] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, D3, 0);
        tbl[14] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 1, h(27'h5, 0, 0), 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 1, h(27'h6, 0, 1), 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 0, D0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[20] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        cyc();
        cyc();
        @(negedge clk_in);
        chk("rst_ready", req_axis_ready, 0);
        chk("rst_valid", resp_axis_valid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_err", protocol_err, 0);
        cyc();
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_ready", req_axis_ready, 1);
        chk("post_rst_valid", resp_axis_valid, 0);
        chk("post_rst_mem_en", mem_en, 0);

        for (int i = 0; i < 22; i++) begin
            e = tbl[i];
            cyc();
            req_axis_valid  = e.v;
            req_axis_tuser  = e.t;
            req_axis_data   = e.d;
            resp_axis_ready = e.rr;
            @(negedge clk_in);
            chk($sformatf("r%0d_ready", i), req_axis_ready, e.e_rdy);
            chk($sformatf("r%0d_mem_en", i), mem_en, e.e_en);
            chk($sformatf("r%0d_err", i), protocol_err, e.e_err);
            chk($sformatf("r%0d_rvalid", i), resp_axis_valid, e.e_rv);
            if (e.e_en) begin
                chk($sformatf("r%0d_wen", i), mem_wen, e.e_wen);
                chk($sformatf("r%0d_addr", i), mem_addr, e.e_addr);
            end
            if (e.e_en && e.e_wen)
                chk($sformatf("r%0d_wdata", i), mem_wdata, e.e_wd);
            if (e.e_rv)
                chk($sformatf("r%0d_rdata", i), resp_axis_data, e.e_rd);
        end
        cyc();
        req_axis_valid = 1'b0;
        req_axis_tuser = 1'b0;

        // backpressure: len 8 with ready low stalls after 4 issues
        clr();
        resp_axis_ready = 1'b0;
        send_beat(1, h(27'h100, 8, 0));
        repeat (15) cyc();
        @(negedge clk_in);
        chk("bp_issued", r_addrs.size(), 4);
        chk("bp_valid_held", resp_axis_valid, 1);
        chk("bp_head_data", resp_axis_data, pat(27'h100));
        cyc();
        resp_axis_ready = 1'b1;
        wait_got(8, 60, "bp_drain");
        repeat (5) cyc();
        @(negedge clk_in);
        chk("bp_beats", got.size(), 8);
        chk("bp_total_issued", r_addrs.size(), 8);
        chk("bp_empty", resp_axis_valid, 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("bp_data%0d", i), gq(i), pat(27'(32'h100 + i)));

        // write aborted by a read header after 2 beats
        cyc();
        clr();
        send_beat(1, h(27'h200, 4, 1));
        send_beat(0, D2);
        send_beat(0, D3);
        send_beat(1, h(27'h10, 1, 0));
        wait_got(1, 20, "abort");
        repeat (4) cyc();
        @(negedge clk_in);
        chk("abort_nwrites", w_addrs.size(), 2);
        chk("abort_w0", wq(0), 27'h200);
        chk("abort_w1", wq(1), 27'h201);
        chk("abort_err_pulses", err_cnt, 1);
        chk("abort_beats", got.size(), 1);
        chk("abort_data", gq(0), pat(27'h10));

        // address wrap
        cyc();
        clr();
        send_beat(1, h(27'h7FFFFFF, 2, 0));
        wait_got(2, 20, "wrap");
        repeat (3) cyc();
        @(negedge clk_in);
        chk("wrap_nreads", r_addrs.size(), 2);
        chk("wrap_a0", rq(0), 27'h7FFFFFF);
        chk("wrap_a1", rq(1), 27'h0);
        chk("wrap_d0", gq(0), pat(27'h7FFFFFF));
        chk("wrap_d1", gq(1), pat(27'h0));

        // back-to-back reads with random downstream ready
        cyc();
        clr();
        rr_rand = 1;
        send_beat(1, h(27'h300, 4, 0));
        send_beat(1, h(27'h310, 4, 0));
        send_beat(1, h(27'h320, 4, 0));
        wait_got(12, 300, "rand");
        rr_rand = 0;
        resp_axis_ready = 1'b1;
        repeat (4) cyc();
        @(negedge clk_in);
        chk("rand_beats", got.size(), 12);
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("rand_d%0d_%0d", j, k), gq(j * 4 + k),
                    pat(27'(32'h300 + j * 16 + k)));

        // reset in the middle of a read
        cyc();
        clr();
        send_beat(1, h(27'h400, 8, 0));
        repeat (2) cyc();
        rst_in = 1'b1;
        cyc();
        cyc();
        @(negedge clk_in);
        chk("mid_rst_ready", req_axis_ready, 0);
        chk("mid_rst_valid", resp_axis_valid, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        cyc();
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("mid_post_ready", req_axis_ready, 1);
        chk("mid_post_valid", resp_axis_valid, 0);
        chk("mid_post_mem_en", mem_en, 0);
        chk("mid_post_err", protocol_err, 0);
        clr();
        cyc();
        send_beat(1, h(27'h500, 2, 0));
        wait_got(2, 20, "post_rst");
        repeat (6) cyc();
        @(negedge clk_in);
        chk("post_rst_beats", got.size(), 2);
        chk("post_rst_d0", gq(0), pat(27'h500));
        chk("post_rst_d1", gq(1), pat(27'h501));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
